// File: rtl/pong_game_ctrl.sv
// Game sequencer for the VGA pong datapath: serve hold, rally motion with wall and
// paddle bounces, point detection, scoring and match end, all advanced on the frame tick.
module pong_game_ctrl #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 10,
    parameter int PADDLE_H    = 50,
    parameter int P1_X        = 0,
    parameter int P2_X        = 630,
    parameter int BALL_SPEED  = 2,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic [8:0] p1_pos,
    input  logic [8:0] p2_pos,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] state,
    output logic       point_p1,
    output logic       point_p2,
    output logic       game_over
);

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    localparam logic [9:0]  CENTER_X  = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [8:0]  CENTER_Y  = 9'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] Y_MAX     = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] LEFT_X    = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] RIGHT_X   = 11'(P2_X - BALL_SIZE);
    localparam logic [10:0] SPEED     = 11'(BALL_SPEED);
    localparam logic [10:0] B_SIZE    = 11'(BALL_SIZE);
    localparam logic [10:0] P_HEIGHT  = 11'(PADDLE_H);
    localparam logic [3:0]  WIN       = 4'(WIN_SCORE);
    localparam logic [6:0]  SERVE_END = 7'(SERVE_TICKS - 1);

    state_t     cur_state;
    logic       dir_x;
    logic       dir_y;
    logic [6:0] serve_cnt;

    logic [10:0] bx, by, p1_top, p2_top;
    logic [10:0] next_x, next_y;
    logic        next_dir_x, next_dir_y;
    logic        hit_p1, hit_p2, at_left, at_right;
    logic        p1_scores, p2_scores;
    logic [3:0]  p1_next, p2_next;

    assign state  = cur_state;
    assign bx     = {1'b0, ball_x};
    assign by     = {2'b0, ball_y};
    assign p1_top = {2'b0, p1_pos};
    assign p2_top = {2'b0, p2_pos};

    // One rally step; dir_x/dir_y are 1 for right/down. Overlap uses the pre-step ball_y.
    always_comb begin
        next_y     = by;
        next_dir_y = dir_y;
        next_x     = bx;
        next_dir_x = dir_x;
        hit_p1     = (by + B_SIZE > p1_top) && (by < p1_top + P_HEIGHT);
        hit_p2     = (by + B_SIZE > p2_top) && (by < p2_top + P_HEIGHT);
        at_left    = !dir_x && (bx < LEFT_X + SPEED);
        at_right   = dir_x && (bx + SPEED > RIGHT_X);
        p1_scores  = at_right && !hit_p2;
        p2_scores  = at_left && !hit_p1;

        if (!dir_y) begin
            if (by < SPEED) begin
                next_y     = 11'd0;
                next_dir_y = 1'b1;
            end else begin
                next_y = by - SPEED;
            end
        end else begin
            if (by + SPEED > Y_MAX) begin
                next_y     = Y_MAX;
                next_dir_y = 1'b0;
            end else begin
                next_y = by + SPEED;
            end
        end

        if (at_left) begin
            next_x     = LEFT_X;
            next_dir_x = 1'b1;
        end else if (at_right) begin
            next_x     = RIGHT_X;
            next_dir_x = 1'b0;
        end else if (dir_x) begin
            next_x = bx + SPEED;
        end else begin
            next_x = bx - SPEED;
        end

        p1_next = (p1_score >= WIN) ? p1_score : p1_score + 4'd1;
        p2_next = (p2_score >= WIN) ? p2_score : p2_score + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= QI;
            ball_x    <= CENTER_X;
            ball_y    <= CENTER_Y;
            p1_score  <= 4'd0;
            p2_score  <= 4'd0;
            point_p1  <= 1'b0;
            point_p2  <= 1'b0;
            game_over <= 1'b0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            serve_cnt <= 7'd0;
        end else begin
            point_p1 <= 1'b0;
            point_p2 <= 1'b0;
            if (!start) begin
                // Abort or leave QDONE: scores are kept for display until the next start.
                cur_state <= QI;
                ball_x    <= CENTER_X;
                ball_y    <= CENTER_Y;
                game_over <= 1'b0;
            end else begin
                case (cur_state)
                    QI: begin
                        cur_state <= QGAME_1;
                        p1_score  <= 4'd0;
                        p2_score  <= 4'd0;
                        ball_x    <= CENTER_X;
                        ball_y    <= CENTER_Y;
                        serve_cnt <= 7'd0;
                        dir_x     <= 1'b1;
                    end
                    QGAME_1: begin
                        if (tick) begin
                            if (serve_cnt == SERVE_END) begin
                                cur_state <= QGAME_2;
                                serve_cnt <= 7'd0;
                            end else begin
                                serve_cnt <= serve_cnt + 7'd1;
                            end
                        end
                    end
                    QGAME_2: begin
                        if (tick) begin
                            if (p1_scores || p2_scores) begin
                                // Point: re-centre and serve toward the player who conceded.
                                ball_x    <= CENTER_X;
                                ball_y    <= CENTER_Y;
                                serve_cnt <= 7'd0;
                                if (p1_scores) begin
                                    p1_score  <= p1_next;
                                    point_p1  <= 1'b1;
                                    dir_x     <= 1'b1;
                                    cur_state <= (p1_next == WIN) ? QDONE : QGAME_1;
                                    game_over <= (p1_next == WIN);
                                end else begin
                                    p2_score  <= p2_next;
                                    point_p2  <= 1'b1;
                                    dir_x     <= 1'b0;
                                    cur_state <= (p2_next == WIN) ? QDONE : QGAME_1;
                                    game_over <= (p2_next == WIN);
                                end
                            end else begin
                                ball_x <= next_x[9:0];
                                ball_y <= next_y[8:0];
                                dir_x  <= next_dir_x;
                                dir_y  <= next_dir_y;
                            end
                        end
                    end
                    QDONE: begin
                        game_over <= 1'b1;
                    end
                    default: cur_state <= QI;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: randomized paddles and tick spacing checked
// every cycle against an integer game model, plus directed serve/abort/reset steps.
module tb_pong_game_ctrl;

    localparam int CX = 316;
    localparam int CY = 236;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       tick;
    logic [8:0] p1_pos;
    logic [8:0] p2_pos;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] state;
    logic       point_p1;
    logic       point_p2;
    logic       game_over;

    int vectors     = 0;
    int miscompares = 0;

    int m_state, m_x, m_y, m_dx, m_dy, m_cnt, m_s1, m_s2, m_pt1, m_pt2;

    pong_game_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick),
        .p1_pos(p1_pos), .p2_pos(p2_pos),
        .ball_x(ball_x), .ball_y(ball_y),
        .p1_score(p1_score), .p2_score(p2_score),
        .state(state), .point_p1(point_p1), .point_p2(point_p2),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("ball_x", 16'(ball_x), 16'(m_x));
        check("ball_y", 16'(ball_y), 16'(m_y));
        check("p1_score", 16'(p1_score), 16'(m_s1));
        check("p2_score", 16'(p2_score), 16'(m_s2));
        check("state", 16'(state), 16'(m_state));
        check("point_p1", 16'(point_p1), 16'(m_pt1));
        check("point_p2", 16'(point_p2), 16'(m_pt2));
        check("game_over", 16'(game_over), 16'(m_state == 3));
    endtask

    task automatic model_reset();
        m_state = 0; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
        m_cnt = 0; m_s1 = 0; m_s2 = 0; m_pt1 = 0; m_pt2 = 0;
    endtask

    // Ball rows [y, y+8) and paddle rows [p, p+50) share at least one row.
    function automatic bit overlaps(int y, int p);
        return (y < p + 50) && (p < y + 8);
    endfunction

    task automatic rally(input int p1, input int p2);
        int scorer = 0;
        int ny = m_y;
        int ndy = m_dy;
        if (m_dy == 1) begin
            ny = m_y + 2;
            if (ny > 472) begin ny = 472; ndy = 0; end
        end else begin
            ny = m_y - 2;
            if (ny < 0) begin ny = 0; ndy = 1; end
        end
        if (m_dx == 0 && m_x - 2 < 10) begin
            if (overlaps(m_y, p1)) begin m_x = 10; m_dx = 1; end
            else scorer = 2;
        end else if (m_dx == 1 && m_x + 2 > 622) begin
            if (overlaps(m_y, p2)) begin m_x = 622; m_dx = 0; end
            else scorer = 1;
        end else begin
            m_x = (m_dx == 1) ? m_x + 2 : m_x - 2;
        end
        if (scorer == 0) begin
            m_y = ny; m_dy = ndy;
        end else begin
            if (scorer == 1) begin
                if (m_s1 < 10) m_s1++;
                m_pt1 = 1; m_dx = 1;
            end else begin
                if (m_s2 < 10) m_s2++;
                m_pt2 = 1; m_dx = 0;
            end
            m_x = CX; m_y = CY; m_cnt = 0;
            m_state = (m_s1 == 10 || m_s2 == 10) ? 3 : 1;
        end
    endtask

    task automatic model_step(input bit s, input bit t, input int p1, input int p2);
        m_pt1 = 0; m_pt2 = 0;
        if (!s) begin
            m_state = 0; m_x = CX; m_y = CY;
        end else if (m_state == 0) begin
            m_state = 1; m_s1 = 0; m_s2 = 0; m_x = CX; m_y = CY; m_cnt = 0; m_dx = 1;
        end else if (m_state == 1 && t) begin
            if (m_cnt == 59) begin m_state = 2; m_cnt = 0; end
            else m_cnt++;
        end else if (m_state == 2 && t) begin
            rally(p1, p2);
        end
    endtask

    task automatic step(input bit s, input bit t);
        start = s;
        tick  = t;
        @(posedge clk);
        model_step(s, t, int'(p1_pos), int'(p2_pos));
        @(negedge clk);
        check_all();
        tick = 1'b0;
    endtask

    // Paddle near the ball, including offsets that land exactly one row off either edge.
    function automatic int track(int y);
        int p = y - (int'($urandom_range(62, 0)) - 8);
        if (p < 0) p = 0;
        if (p > 430) p = 430;
        return p;
    endfunction

    function automatic int far_pos(int y);
        return (y < 240) ? 430 : 0;
    endfunction

    task automatic serve();
        int guard = 0;
        while (m_state == 1 && guard < 400) begin
            step(1'b1, $urandom_range(3, 0) != 0);
            guard++;
        end
        check("serve_to_rally", 16'(state), 16'd2);
    endtask

    initial begin
        int guard;
        reset = 1'b1; start = 1'b0; tick = 1'b0; p1_pos = '0; p2_pos = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b1);
        check("idle_ignores_tick", 16'(state), 16'd0);

        step(1'b1, 1'b0);
        check("start_state", 16'(state), 16'd1);
        serve();
        step(1'b1, 1'b1);
        check("first_rally_x", 16'(ball_x), 16'd318);
        check("first_rally_y", 16'(ball_y), 16'd238);

        guard = 0;
        while (m_state != 3 && guard < 40000) begin
            p1_pos = 9'(($urandom_range(3, 0) != 0) ? track(m_y) : int'($urandom_range(430, 0)));
            p2_pos = 9'(($urandom_range(4, 0) == 0) ? track(m_y) : int'($urandom_range(430, 0)));
            step(1'b1, $urandom_range(2, 0) != 0);
            guard++;
        end
        check("match_over", 16'(game_over), 16'd1);
        check("winner_at_ten", 16'(p1_score == 4'd10 || p2_score == 4'd10), 16'd1);
        repeat (5) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        check("done_to_idle", 16'(state), 16'd0);

        step(1'b1, 1'b0);
        check("restart_clears_p1", 16'(p1_score), 16'd0);
        serve();
        guard = 0;
        while (!((m_dx == 0 && m_x < 12) || (m_dx == 1 && m_x > 620)) && guard < 1000) begin
            p1_pos = 9'(far_pos(m_y));
            p2_pos = 9'(far_pos(m_y));
            step(1'b1, 1'b1);
            guard++;
        end
        p1_pos = 9'(far_pos(m_y));
        p2_pos = 9'(far_pos(m_y));
        step(1'b0, 1'b1);
        check("abort_state", 16'(state), 16'd0);
        check("abort_no_point", 16'(point_p1 | point_p2), 16'd0);

        step(1'b1, 1'b0);
        serve();
        repeat (10) step(1'b1, 1'b1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
